// File: rtl/bus_pkg.sv
// bus_pkg: bus source codes, idle select code and arbiter state type shared by the bus select encoder and arbiter.
package bus_pkg;
  localparam int R0 = 0;
  localparam int R1 = 1;
  localparam int R2 = 2;
  localparam int R3 = 3;
  localparam int R4 = 4;
  localparam int R5 = 5;
  localparam int R6 = 6;
  localparam int R7 = 7;
  localparam int R8 = 8;
  localparam int R9 = 9;
  localparam int R10 = 10;
  localparam int R11 = 11;
  localparam int R12 = 12;
  localparam int R13 = 13;
  localparam int R14 = 14;
  localparam int R15 = 15;
  localparam int HI = 16;
  localparam int LO = 17;
  localparam int PC = 18;
  localparam int MDR = 19;
  localparam int INPORT = 20;
  localparam int ZHI = 21;
  localparam int ZLO = 22;
  localparam int C = 23;
  localparam logic [4:0] SEL_IDLE = 5'b11111;
  typedef enum logic {IDLE, OWNED} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker; first set, non-excluded req bit at or after start, wrapping modulo N.
module rr_pick #(
  parameter int N = 24,
  parameter int W = 5
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic [N-1:0] excl,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [N-1:0]   m;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     s;
  // Rotate the candidates so bit 0 is the start position; wrap never touches indices >= N.
  always_comb begin
    m = req & ~excl;
    dbl = {m, m} >> start;
    rot = dbl[N-1:0];
    found = 1'b0;
    idx = '0;
    s = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        s = {1'b0, start} + (W+1)'(k);
        idx = (s >= (W+1)'(N)) ? W'(s - (W+1)'(N)) : s[W-1:0];
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with registered one-hot grant, select code and a tenure limit.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_SRC  = 24,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               owner_change
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  arb_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d, last_q, last_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               busy_q, busy_d, oc_q, oc_d;
  logic [SEL_W-1:0]   start, pick;
  logic               found, own_req, at_max, sw, stay;
  assign start = (last_q == SEL_W'(NUM_SRC - 1)) ? '0 : last_q + 1'b1;
  // Excluding the current grant keeps the owner out of a forced switch; on release its req is already low.
  rr_pick #(.N(NUM_SRC), .W(SEL_W)) u_pick (
    .req   (req),
    .start (start),
    .excl  (grant_q),
    .found (found),
    .idx   (pick)
  );
  always_comb begin
    own_req = (state_q == OWNED) && |(req & grant_q);
    at_max = (hold_q == HW'(MAX_HOLD));
    sw = found && (!own_req || at_max);
    stay = own_req && !sw;
    state_d = (sw || stay) ? OWNED : IDLE;
    grant_d = sw ? NUM_SRC'(1) << pick : stay ? grant_q : '0;
    sel_d = sw ? pick : stay ? sel_q : SEL_W'(SEL_IDLE);
    hold_d = sw ? HW'(1) : stay ? (at_max ? hold_q : hold_q + 1'b1) : '0;
    last_d = sw ? pick : last_q;
    busy_d = sw || stay;
    oc_d = sw;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q <= SEL_W'(SEL_IDLE);
      last_q <= SEL_W'(NUM_SRC - 1);
      hold_q <= '0;
      busy_q <= 1'b0;
      oc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q <= sel_d;
      last_q <= last_d;
      hold_q <= hold_d;
      busy_q <= busy_d;
      oc_q <= oc_d;
    end
  end
  assign grant = grant_q;
  assign sel = sel_q;
  assign busy = busy_q;
  assign owner_change = oc_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed-vector bench for bus_arbiter with default parameters.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] req;
  logic [23:0] grant;
  logic [4:0]  sel;
  logic        busy, owner_change;
  logic [30:0] obs;
  int          nvec = 0;
  int          nerr = 0;

  bus_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .grant        (grant),
    .sel          (sel),
    .busy         (busy),
    .owner_change (owner_change)
  );

  always #5 clk = ~clk;
  assign obs = {grant, sel, busy, owner_change};

  function automatic logic [30:0] e(int who, logic oc);
    logic [23:0] g;
    g = 24'h1 << who;
    if (who < 0) return {24'h0, 5'h1f, 2'b00};
    return {g, 5'(who), 1'b1, oc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    tick();
    nvec++;
    if (obs !== e(-1, 0)) begin nerr++; $display("FAIL reset got %h want %h", obs, e(-1, 0)); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (obs !== e(-1, 0)) begin nerr++; $display("FAIL idle_%0d got %h want %h", i, obs, e(-1, 0)); end
    end
  endtask

  task automatic test_single_pc();
    req = 24'h1 << 18;
    tick();
    nvec++;
    if (obs !== e(18, 1)) begin nerr++; $display("FAIL pc_grant got %h want %h", obs, e(18, 1)); end
    for (int i = 0; i < 4; i++) begin
      tick();
      nvec++;
      if (obs !== e(18, 0)) begin nerr++; $display("FAIL pc_hold_%0d got %h want %h", i, obs, e(18, 0)); end
    end
    req = '0;
    tick();
    nvec++;
    if (obs !== e(-1, 0)) begin nerr++; $display("FAIL pc_release got %h want %h", obs, e(-1, 0)); end
  endtask

  task automatic test_rotation();
    int seq[12] = '{2, 2, 2, 2, 19, 19, 19, 19, 2, 2, 2, 2};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = (24'h1 << 2) | (24'h1 << 19);
    for (int i = 0; i < 12; i++) begin
      tick();
      nvec++;
      if (obs !== e(seq[i], i % 4 == 0)) begin nerr++; $display("FAIL rot_%0d got %h want %h", i, obs, e(seq[i], i % 4 == 0)); end
    end
    req = '0;
    tick();
    nvec++;
    if (obs !== e(-1, 0)) begin nerr++; $display("FAIL rot_idle got %h want %h", obs, e(-1, 0)); end
  endtask

  task automatic test_wrap();
    req = 24'h1 << 23;
    tick();
    nvec++;
    if (obs !== e(23, 1)) begin nerr++; $display("FAIL wrap_c got %h want %h", obs, e(23, 1)); end
    req = '0;
    tick();
    req = (24'h1 << 0) | (24'h1 << 5);
    tick();
    nvec++;
    if (obs !== e(0, 1)) begin nerr++; $display("FAIL wrap_r0 got %h want %h", obs, e(0, 1)); end
    req = 24'h1 << 5;
    tick();
    nvec++;
    if (obs !== e(5, 1)) begin nerr++; $display("FAIL wrap_r5 got %h want %h", obs, e(5, 1)); end
  endtask

  task automatic test_no_bubble();
    req = 24'h1 << 7;
    tick();
    nvec++;
    if (obs !== e(7, 1)) begin nerr++; $display("FAIL nb_r7 got %h want %h", obs, e(7, 1)); end
    tick();
    nvec++;
    if (obs !== e(7, 0)) begin nerr++; $display("FAIL nb_r7_hold got %h want %h", obs, e(7, 0)); end
    req = 24'h1 << 17;
    tick();
    nvec++;
    if (obs !== e(17, 1)) begin nerr++; $display("FAIL nb_lo got %h want %h", obs, e(17, 1)); end
  endtask

  task automatic test_reset_mid();
    int seq[5] = '{16, 16, 16, 16, 17};
    req = 24'h1 << 16;
    tick();
    nvec++;
    if (obs !== e(16, 1)) begin nerr++; $display("FAIL rm_hi got %h want %h", obs, e(16, 1)); end
    tick();
    tick();
    nvec++;
    if (obs !== e(16, 0)) begin nerr++; $display("FAIL rm_hi_h3 got %h want %h", obs, e(16, 0)); end
    reset = 1'b1;
    tick();
    nvec++;
    if (obs !== e(-1, 0)) begin nerr++; $display("FAIL rm_reset got %h want %h", obs, e(-1, 0)); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (obs !== e(seq[i], i == 0 || i == 4)) begin nerr++; $display("FAIL rm_regrant_%0d got %h want %h", i, obs, e(seq[i], i == 0 || i == 4)); end
      req = (24'h1 << 16) | (24'h1 << 17);
    end
  endtask

  initial begin
    test_reset();
    test_single_pc();
    test_rotation();
    test_wrap();
    test_no_bubble();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
